// File: rtl/expand_pcm_pkg.sv
// Shared constants for the G.711 log-PCM to linear-PCM expander.
package expand_pcm_pkg;

    localparam int unsigned SL_W = 14;
    localparam int unsigned S_W  = 8;

    localparam logic LAW_A = 1'b1;
    localparam logic LAW_U = 1'b0;

    localparam logic [S_W-1:0] ALAW_XOR = 8'h55;
    localparam logic [S_W-1:0] ULAW_XOR = 8'hFF;

    // u-law bias, and the implicit leading-one offset of A-law segments >= 1
    localparam logic [SL_W-1:0] ULAW_BIAS     = 14'd33;
    localparam logic [SL_W-1:0] ALAW_MANT_OFS = 14'd33;

endpackage

// File: rtl/expand_pcm_if.sv
// Log-PCM input stream and linear-PCM output stream, each with valid/ready.
interface expand_pcm_if
    import expand_pcm_pkg::*;
();
    logic            in_valid;
    logic            in_ready;
    logic [S_W-1:0]  S;
    logic            LAW;
    logic            out_valid;
    logic            out_ready;
    logic [SL_W-1:0] SL;

    modport slave (
        input  in_valid, S, LAW, out_ready,
        output in_ready, out_valid, SL
    );

    modport master (
        output in_valid, S, LAW, out_ready,
        input  in_ready, out_valid, SL
    );
endinterface

// File: rtl/expand_mag.sv
// Combinational magnitude expansion {law, exp, mant} -> 14-bit unsigned magnitude.
module expand_mag
    import expand_pcm_pkg::*;
(
    input  logic            law_i,
    input  logic [2:0]      exp_i,
    input  logic [3:0]      mant_i,
    output logic [SL_W-1:0] mag_o
);
    logic [SL_W-1:0] mant2;

    // A-law segment 0 has no implicit leading one; the final <<1 maps 13-bit A-law onto 14 bits
    always_comb begin
        mant2 = {{(SL_W-5){1'b0}}, mant_i, 1'b0};
        if (law_i == LAW_U) begin
            mag_o = ((mant2 + ULAW_BIAS) << exp_i) - ULAW_BIAS;
        end else if (exp_i == 3'd0) begin
            mag_o = (mant2 | {{(SL_W-1){1'b0}}, 1'b1}) << 1;
        end else begin
            mag_o = ((mant2 + ALAW_MANT_OFS) << (exp_i - 3'd1)) << 1;
        end
    end
endmodule

// File: rtl/expand_pcm.sv
// Two-stage elastic pipeline: stage 1 decodes sign/exp/mant, stage 2 holds linear SL.
module expand_pcm
    import expand_pcm_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    expand_pcm_if.slave      bus,
    output logic [CNT_W-1:0] sample_cnt
);
    logic            s1_full_q, s1_full_d;
    logic            s1_neg_q, s1_neg_d;
    logic            s1_law_q, s1_law_d;
    logic [2:0]      s1_exp_q, s1_exp_d;
    logic [3:0]      s1_mant_q, s1_mant_d;
    logic            s2_valid_q, s2_valid_d;
    logic [SL_W-1:0] sl_q, sl_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic            s2_free, s1_adv, in_xfer, out_xfer;
    logic [S_W-1:0]  c;
    logic [SL_W-1:0] mag;

    expand_mag u_mag (
        .law_i  (s1_law_q),
        .exp_i  (s1_exp_q),
        .mant_i (s1_mant_q),
        .mag_o  (mag)
    );

    // Handshake and flow control; in_ready sees out_ready combinationally
    always_comb begin
        out_xfer     = s2_valid_q && bus.out_ready;
        s2_free      = !s2_valid_q || bus.out_ready;
        s1_adv       = s1_full_q && s2_free;
        bus.in_ready = !s1_full_q || s1_adv;
        in_xfer      = bus.in_valid && bus.in_ready;
    end

    // Next-state for both stages and the delivered-sample counter
    always_comb begin
        c         = (bus.LAW == LAW_A) ? (bus.S ^ ALAW_XOR) : (bus.S ^ ULAW_XOR);
        s1_neg_d  = s1_neg_q;
        s1_law_d  = s1_law_q;
        s1_exp_d  = s1_exp_q;
        s1_mant_d = s1_mant_q;
        s1_full_d = s1_full_q;
        if (in_xfer) begin
            // A-law sign bit set means positive; u-law sign bit set means negative
            s1_neg_d  = (bus.LAW == LAW_A) ? !c[7] : c[7];
            s1_law_d  = bus.LAW;
            s1_exp_d  = c[6:4];
            s1_mant_d = c[3:0];
            s1_full_d = 1'b1;
        end else if (s1_adv) begin
            s1_full_d = 1'b0;
        end

        s2_valid_d = s2_free ? s1_full_q : s2_valid_q;
        sl_d       = sl_q;
        if (s1_adv) begin
            // -0 in two's complement is 0, so u-law negative zero needs no special case
            sl_d = s1_neg_q ? (SL_W'(0) - mag) : mag;
        end

        cnt_d = out_xfer ? (cnt_q + CNT_W'(1)) : cnt_q;
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_full_q  <= 1'b0;
            s1_neg_q   <= 1'b0;
            s1_law_q   <= LAW_U;
            s1_exp_q   <= 3'd0;
            s1_mant_q  <= 4'd0;
            s2_valid_q <= 1'b0;
            sl_q       <= '0;
            cnt_q      <= '0;
        end else begin
            s1_full_q  <= s1_full_d;
            s1_neg_q   <= s1_neg_d;
            s1_law_q   <= s1_law_d;
            s1_exp_q   <= s1_exp_d;
            s1_mant_q  <= s1_mant_d;
            s2_valid_q <= s2_valid_d;
            sl_q       <= sl_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.out_valid = s2_valid_q;
    assign bus.SL        = sl_q;
    assign sample_cnt    = cnt_q;
endmodule

// File: tb/tb_expand_pcm.sv
// Directed bench for expand_pcm: known codes, backpressure, law switching, full sweep, reset.
module tb_expand_pcm;
    import expand_pcm_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] sample_cnt;
    int          tests = 0;
    int          fails = 0;

    expand_pcm_if bus ();

    expand_pcm #(.CNT_W(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .sample_cnt (sample_cnt)
    );

    always #5 clk = ~clk;

    // ITU-style reference decoders, returning the 16-bit-scale value
    function automatic int alaw_ref(input logic [7:0] code);
        int a, t, seg;
        a   = int'(code) ^ 32'h55;
        t   = (a & 32'h0F) << 4;
        seg = (a & 32'h70) >> 4;
        if (seg == 0) t = t + 8;
        else if (seg == 1) t = t + 32'h108;
        else t = (t + 32'h108) << (seg - 1);
        return ((a & 32'h80) != 0) ? t : -t;
    endfunction

    function automatic int ulaw_ref(input logic [7:0] code);
        int u, t;
        u = int'(~code) & 32'hFF;
        t = (((u & 32'h0F) << 3) + 32'h84) << ((u & 32'h70) >> 4);
        return ((u & 32'h80) != 0) ? (32'h84 - t) : (t - 32'h84);
    endfunction

    function automatic logic [13:0] ref14(input logic law, input logic [7:0] code);
        int v;
        v = (law == LAW_A) ? alaw_ref(code) : ulaw_ref(code);
        return 14'(v >>> 2);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        reset_n       = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Offers 4 samples back to back with out_ready=1; records each SL and the cycle it was seen
    task automatic run_stream(input logic [3:0] laws, input logic [31:0] codes,
                              output logic [55:0] got, output logic [31:0] cyc, output int ngot);
        ngot = 0;
        got  = '0;
        cyc  = '0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k < 4) begin
                bus.in_valid = 1'b1;
                bus.S        = codes[8*k +: 8];
                bus.LAW      = laws[k];
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (bus.out_valid) begin
                if (ngot < 4) begin
                    got[14*ngot +: 14] = bus.SL;
                    cyc[8*ngot +: 8]   = 8'(k);
                end
                ngot++;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        tests++;
        if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        tests++;
        if (bus.SL !== 14'h0000) begin fails++; $display("FAIL reset_sl got %h want 0000", bus.SL); end
        tests++;
        if (sample_cnt !== 16'd0) begin fails++; $display("FAIL reset_cnt got %0d want 0", sample_cnt); end
        tests++;
        if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    endtask

    // Expected values and latency (cycle k accepted -> seen valid in cycle k+2)
    task automatic check_stream(input string name, input logic [3:0] laws, input logic [31:0] codes,
                                input logic [55:0] exp_sl);
        logic [55:0] got;
        logic [31:0] cyc;
        int          ngot;
        run_stream(laws, codes, got, cyc, ngot);
        tests++;
        if (ngot !== 4) begin fails++; $display("FAIL %s_count got %0d want 4", name, ngot); end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (got[14*i +: 14] !== exp_sl[14*i +: 14]) begin
                fails++;
                $display("FAIL %s_sl%0d got %h want %h", name, i, got[14*i +: 14], exp_sl[14*i +: 14]);
            end
            tests++;
            if (cyc[8*i +: 8] !== 8'(i + 2)) begin
                fails++;
                $display("FAIL %s_lat%0d got cycle %0d want %0d", name, i, cyc[8*i +: 8], i + 2);
            end
        end
    endtask

    task automatic test_ulaw();
        // FF -> +0, 7F -> -0 = 0, 80 -> +8031, 00 -> -8031
        check_stream("ulaw", {4{LAW_U}}, {8'h00, 8'h80, 8'h7F, 8'hFF},
                     {14'h20A1, 14'h1F5F, 14'h0000, 14'h0000});
    endtask

    task automatic test_alaw();
        // D5 -> +2, 55 -> -2, AA -> +8064, 2A -> -8064
        check_stream("alaw", {4{LAW_A}}, {8'h2A, 8'hAA, 8'h55, 8'hD5},
                     {14'h2080, 14'h1F80, 14'h3FFE, 14'h0002});
    endtask

    task automatic test_law_switch();
        // S=D5: A-law c=80 -> +2; u-law c=~D5=2A (positive, exp 2, mant 10) -> (53<<2)-33 = 179
        check_stream("lawsw", {LAW_U, LAW_A, LAW_U, LAW_A}, {4{8'hD5}},
                     {14'h00B3, 14'h0002, 14'h00B3, 14'h0002});
    endtask

    task automatic test_backpressure();
        logic [7:0]  codes [3];
        logic [13:0] got [4];
        int          acc = 0;
        int          ngot = 0;
        codes[0] = 8'hD5;
        codes[1] = 8'h55;
        codes[2] = 8'hAA;
        bus.out_ready = 1'b0;
        bus.LAW       = LAW_A;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.S        = codes[(acc < 3) ? acc : 2];
            #1;
            if (k == 2) begin
                tests++;
                if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready got %b want 0", bus.in_ready); end
            end
            if (k >= 2) begin
                tests++;
                if (bus.out_valid !== 1'b1 || bus.SL !== 14'h0002) begin
                    fails++;
                    $display("FAIL bp_hold k=%0d got v=%b sl=%h want v=1 sl=0002", k, bus.out_valid, bus.SL);
                end
            end
            if (bus.in_ready) acc++;
        end
        tests++;
        if (acc !== 2) begin fails++; $display("FAIL bp_accepted got %0d want 2", acc); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
            #1;
            if (bus.out_valid) begin
                if (ngot < 4) got[ngot] = bus.SL;
                ngot++;
            end
        end
        tests++;
        if (ngot !== 2) begin fails++; $display("FAIL bp_drain_count got %0d want 2", ngot); end
        else begin
            tests++;
            if (got[0] !== 14'h0002 || got[1] !== 14'h3FFE) begin
                fails++;
                $display("FAIL bp_order got %h,%h want 0002,3FFE", got[0], got[1]);
            end
        end
        tests++;
        if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL bp_drained got %b want 0", bus.out_valid); end
    endtask

    task automatic test_sweep();
        logic [13:0] q [$];
        logic [13:0] e;
        int          sent = 0;
        int          ndone = 0;
        do_reset();
        for (int c = 0; c < 6000 && ndone < 512; c++) begin
            @(negedge clk);
            if (sent < 512 && $urandom_range(3) != 0) begin
                bus.in_valid = 1'b1;
                bus.LAW      = sent[0];
                bus.S        = sent[8:1];
            end else begin
                bus.in_valid = 1'b0;
            end
            bus.out_ready = ($urandom_range(3) != 0);
            #1;
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(ref14(bus.LAW, bus.S));
                sent++;
            end
            if (bus.out_valid && bus.out_ready) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL sweep_extra got %h want nothing", bus.SL);
                end else begin
                    e = q.pop_front();
                    if (bus.SL !== e) begin
                        fails++;
                        $display("FAIL sweep_sl n=%0d got %h want %h", ndone, bus.SL, e);
                    end
                end
                ndone++;
            end
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        tests++;
        if (ndone !== 512) begin fails++; $display("FAIL sweep_timeout got %0d want 512", ndone); end
        tests++;
        if (sample_cnt !== 16'd512) begin fails++; $display("FAIL sweep_cnt got %0d want 512", sample_cnt); end
    endtask

    task automatic test_reset_midflight();
        logic [55:0] got;
        logic [31:0] cyc;
        int          ngot;
        bus.out_ready = 1'b0;
        bus.LAW       = LAW_U;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.S        = (k == 0) ? 8'h00 : 8'h7F;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        tests++;
        if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL mid_inflight got %b want 1", bus.out_valid); end
        reset_n = 1'b0;
        #1;
        tests++;
        if (bus.out_valid !== 1'b0 || sample_cnt !== 16'd0) begin
            fails++;
            $display("FAIL mid_reset got v=%b cnt=%0d want v=0 cnt=0", bus.out_valid, sample_cnt);
        end
        @(negedge clk);
        reset_n = 1'b1;
        run_stream({4{LAW_U}}, {8'hFF, 8'h80, 8'hFF, 8'h80}, got, cyc, ngot);
        tests++;
        if (ngot !== 4 || got[13:0] !== 14'h1F5F || cyc[7:0] !== 8'd2) begin
            fails++;
            $display("FAIL mid_first got n=%0d sl=%h cyc=%0d want n=4 sl=1F5F cyc=2",
                     ngot, got[13:0], cyc[7:0]);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.S         = 8'h00;
        bus.LAW       = LAW_U;
        test_reset();
        test_ulaw();
        test_alaw();
        test_law_switch();
        test_backpressure();
        test_sweep();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
